// File: rtl/wbc_seg_pkg.sv
// rtl/wbc_seg_pkg.sv - shared helpers and polarity constants for segment display scanners
package wbc_seg_pkg;

  localparam int ACT_LOW  = 1;
  localparam int ACT_HIGH = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Index width for a scan of n digits; a single digit still needs a 1-bit index.
  function automatic int slot_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/wbc_segpwm.sv
// rtl/wbc_segpwm.sv - free-running brightness PWM, on while counter <= dim
module wbc_segpwm #(
  parameter int DIM_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIM_W-1:0] dim,
  output logic             on
);

  logic [DIM_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

  assign on = (cnt <= dim);

endmodule

// File: rtl/wbc_segscan.sv
// rtl/wbc_segscan.sv - multiplexed 7-segment scanner with guard cycle and blanking
// Optional brightness PWM enabled by defining CONFIG_SEGSCAN_DIM_EN.
module wbc_segscan
  import wbc_seg_pkg::*;
#(
  parameter int DIGITS      = 6,
  parameter int SEG_W       = 8,
  parameter int SEG_ACT_LOW = ACT_LOW,
  parameter int SEL_ACT_LOW = ACT_LOW,
  parameter int DIM_W       = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena_ms,
  input  logic [DIGITS*SEG_W-1:0]     seg_data,
  input  logic [DIGITS-1:0]           dig_ena,
  input  logic                        blank,
  input  logic [DIM_W-1:0]            dim,
  output logic [SEG_W-1:0]            seg_out,
  output logic [DIGITS-1:0]           sel_out,
  output logic [slot_w(DIGITS)-1:0]   slot,
  output logic                        frame
);

  localparam int SLOT_W = slot_w(DIGITS);
  localparam logic [SEG_W-1:0]  SEG_OFF = {SEG_W{SEG_ACT_LOW != 0}};
  localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{SEL_ACT_LOW != 0}};

  logic              pwm_on;
  logic              guard;
  logic              lit;
  logic [SEG_W-1:0]  pat;
  logic [DIGITS-1:0] sel_hot;

`ifdef CONFIG_SEGSCAN_DIM_EN
  wbc_segpwm #(.DIM_W(DIM_W)) u_pwm (
    .clk   (clk),
    .rst_n (rst_n),
    .dim   (dim),
    .on    (pwm_on)
  );
`else
  logic unused_dim;
  assign unused_dim = ^dim;
  assign pwm_on     = 1'b1;
`endif

  // Outputs are registered, so blanking on the stepping edge darkens the clk after ena_ms.
  assign guard   = ena_ms;
  assign lit     = !guard && !blank && dig_ena[slot] && pwm_on;
  assign pat     = seg_data[slot*SEG_W +: SEG_W];
  assign sel_hot = DIGITS'(1) << slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot    <= '0;
      frame   <= 1'b0;
      seg_out <= SEG_OFF;
      sel_out <= SEL_OFF;
    end else begin
      frame <= ena_ms && (slot == '0);
      if (ena_ms) slot <= (slot == '0) ? SLOT_W'(DIGITS - 1) : slot - 1'b1;
      seg_out <= (lit ? pat : '0) ^ SEG_OFF;
      sel_out <= (lit ? sel_hot : '0) ^ SEL_OFF;
    end
  end

endmodule

// File: tb/tb_wbc_segscan.sv
// tb/tb_wbc_segscan.sv - directed table-driven bench for wbc_segscan
module tb_wbc_segscan;

  localparam int DIGITS = 6;
  localparam int SEG_W  = 8;
  localparam int DIM_W  = 3;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    ena_ms = 1'b0;
  logic [DIGITS*SEG_W-1:0] seg_data = '0;
  logic [DIGITS-1:0]       dig_ena = '1;
  logic                    blank = 1'b0;
  logic [DIM_W-1:0]        dim = 3'd7;
  logic [SEG_W-1:0]        seg_out;
  logic [DIGITS-1:0]       sel_out;
  logic [2:0]              slot;
  logic                    frame;

  int n_cmp = 0;
  int n_bad = 0;

  wbc_segscan #(.DIGITS(DIGITS), .SEG_W(SEG_W), .SEG_ACT_LOW(1), .SEL_ACT_LOW(1), .DIM_W(DIM_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena_ms   (ena_ms),
    .seg_data (seg_data),
    .dig_ena  (dig_ena),
    .blank    (blank),
    .dim      (dim),
    .seg_out  (seg_out),
    .sel_out  (sel_out),
    .slot     (slot),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         target;
    logic [7:0] pat;
    logic [5:0] ena;
    logic       blk;
    logic [7:0] exp_seg;
    logic [5:0] exp_sel;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    ena_ms = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ena_ms = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [47:0] put(input logic [47:0] base, input int idx, input logic [7:0] p);
    logic [47:0] r;
    r = base;
    r[idx*8 +: 8] = p;
    return r;
  endfunction

  task automatic count_lit(input int n, output int lit_n);
    lit_n = 0;
    repeat (n) begin
      @(negedge clk);
      if (sel_out !== 6'h3F) lit_n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int exp_slots[7];
    int dark_bad;
    int lit_n;
    exp_slots = '{5, 4, 3, 2, 1, 0, 5};

    vecs[0] = '{3, 8'h3F, 6'h3F, 1'b0, 8'hC0, 6'h37};
    vecs[1] = '{2, 8'h5B, 6'h3B, 1'b0, 8'hFF, 6'h3F};
    vecs[2] = '{1, 8'h06, 6'h3F, 1'b1, 8'hFF, 6'h3F};
    vecs[3] = '{0, 8'h80, 6'h3F, 1'b0, 8'h7F, 6'h3E};
    vecs[4] = '{5, 8'h7F, 6'h3F, 1'b0, 8'h80, 6'h1F};
    vecs[5] = '{4, 8'h00, 6'h3F, 1'b0, 8'hFF, 6'h2F};

    // Reset state
    idle(3);
    chk("rst_slot", slot, 0);
    chk("rst_frame", frame, 0);
    chk("rst_seg", seg_out, 8'hFF);
    chk("rst_sel", sel_out, 6'h3F);
    rst_n = 1'b1;
    idle(1);
    chk("post_rst_slot", slot, 0);

    // Scan sequence with a step every 10 clk
    for (int i = 0; i < 7; i++) begin
      idle(9);
      step();
      chk($sformatf("seq_slot_%0d", i), slot, exp_slots[i]);
      chk($sformatf("seq_frame_%0d", i), frame, (exp_slots[i] == 5) ? 1 : 0);
      idle(1);
      chk($sformatf("seq_frame_low_%0d", i), frame, 0);
    end

    // Table-driven per-slot display vectors
    for (int v = 0; v < 6; v++) begin
      seg_data = '0;
      for (int d = 0; d < DIGITS; d++) seg_data = put(seg_data, d, 8'(8'h11 * (d + 1)));
      seg_data = put(seg_data, vecs[v].target, vecs[v].pat);
      dig_ena  = vecs[v].ena;
      blank    = vecs[v].blk;
      step();
      for (int k = 0; k < 6 && slot != 3'(vecs[v].target); k++) step();
      chk($sformatf("vec%0d_slot", v), slot, vecs[v].target);
      chk($sformatf("vec%0d_guard_seg", v), seg_out, 8'hFF);
      chk($sformatf("vec%0d_guard_sel", v), sel_out, 6'h3F);
      idle(1);
      chk($sformatf("vec%0d_seg", v), seg_out, vecs[v].exp_seg);
      chk($sformatf("vec%0d_sel", v), sel_out, vecs[v].exp_sel);
    end
    blank   = 1'b0;
    dig_ena = 6'h3F;

    // seg_data change shows on the next clk, no frame wait
    seg_data = put(seg_data, 4, 8'h6D);
    idle(1);
    chk("live_seg", seg_out, 8'h92);
    chk("live_sel", sel_out, 6'h2F);

    // Blank together with ena_ms: slot still advances
    seg_data = 48'h66_55_44_33_22_11;
    blank = 1'b1;
    step();
    chk("blank_slot", slot, 3);
    idle(1);
    chk("blank_seg", seg_out, 8'hFF);
    chk("blank_sel", sel_out, 6'h3F);
    blank = 1'b0;
    idle(1);
    chk("unblank_seg", seg_out, 8'hBB);
    chk("unblank_sel", sel_out, 6'h37);

    // ena_ms every clk keeps the display dark
    dark_bad = 0;
    ena_ms = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (sel_out !== 6'h3F || seg_out !== 8'hFF) dark_bad++;
    end
    ena_ms = 1'b0;
    chk("always_guard_dark", dark_bad, 0);
    chk("always_guard_slot", slot, 3);
    idle(1);
    chk("after_guard_seg", seg_out, 8'hBB);

    // Brightness
`ifdef CONFIG_SEGSCAN_DIM_EN
    dim = 3'd1;
    idle(1);
    count_lit(16, lit_n);
    chk("dim1_lit", lit_n, 4);
    dim = 3'd7;
    idle(1);
    count_lit(16, lit_n);
    chk("dim7_lit", lit_n, 16);
`else
    dim = 3'd0;
    idle(1);
    count_lit(16, lit_n);
    chk("dim_ignored_lit", lit_n, 16);
`endif
    dim = 3'd7;

    // Asynchronous reset in the middle of slot 4
    step();
    for (int k = 0; k < 6 && slot != 3'd4; k++) step();
    chk("pre_rst_slot", slot, 4);
    idle(2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_seg", seg_out, 8'hFF);
    chk("async_rst_sel", sel_out, 6'h3F);
    chk("async_rst_slot", slot, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("rel_slot", slot, 0);
    step();
    chk("rel_step_slot", slot, 5);
    chk("rel_step_frame", frame, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wbc_segscan.md
WBC_SEGSCAN -- requirements
Module: wbc_segscan

Interface
REQ-001 SHALL provide parameter DIGITS, default 6: number of multiplexed digits, range 1..16.
REQ-002 SHALL provide parameter SEG_W, default 8: segment lines per digit, including the decimal point.
REQ-003 SHALL provide parameter SEG_ACT_LOW, default 1: segment outputs are active-low when 1.
REQ-004 SHALL provide parameter SEL_ACT_LOW, default 1: digit-select outputs are active-low when 1.
REQ-005 SHALL provide parameter DIM_W, default 3: width of the brightness control.
REQ-006 SHALL provide port clk  in  1: single system clock, all logic on posedge.
REQ-007 SHALL provide port rst_n  in  1: reset, asynchronous, active-low.
REQ-008 SHALL provide port ena_ms  in  1: one-clk scan-step strobe.
REQ-009 SHALL provide port seg_data  in  DIGITS*SEG_W: active-high segment patterns; digit i occupies bits [i*SEG_W +: SEG_W].
REQ-010 SHALL provide port dig_ena  in  DIGITS: per-digit enable; a digit whose bit is 0 is blanked but keeps its time slot.
REQ-011 SHALL provide port blank  in  1: global blank.
REQ-012 SHALL provide port dim  in  DIM_W: brightness level.
REQ-013 SHALL provide port seg_out  out  SEG_W: segment drive, polarity per SEG_ACT_LOW.
REQ-014 SHALL provide port sel_out  out  DIGITS: one-hot digit select, polarity per SEL_ACT_LOW.
REQ-015 SHALL provide port slot  out  clog2(DIGITS), minimum 1: current scan index.
REQ-016 SHALL provide port frame  out  1: one-clk pulse at the start of each scan frame.

Function
REQ-017 SHALL hold the scan index in slot; on each clk with ena_ms=1, slot SHALL decrement, wrapping from 0 to DIGITS-1.
REQ-018 SHALL pulse frame for exactly one clk, registered, in the cycle after slot wraps to DIGITS-1; with DIGITS=1 it SHALL pulse on every ena_ms.
REQ-019 SHALL register seg_out and sel_out with one-clk latency: values reflect slot, seg_data, dig_ena, blank and dim from the previous clk; seg_data changes SHALL appear on the next clk with no frame wait.
REQ-020 SHALL force a guard cycle in the clk after any ena_ms: all sel_out inactive and all seg_out inactive, as anti-ghosting.
REQ-021 SHALL drive the digit lit state = !guard & !blank & dig_ena[slot] & pwm_on.
REQ-022 When the digit is lit, sel_out SHALL activate only bit slot and seg_out SHALL carry seg_data of slot; otherwise all outputs SHALL be at their inactive level.
REQ-023 SHALL keep slot advancing on ena_ms while blank=1; blanking SHALL affect outputs only.
REQ-024 With ena_ms asserted on every clk, the display SHALL stay permanently dark because every cycle is a guard cycle; this is required behaviour, not an error.
REQ-025 Any dim change SHALL take effect on the next PWM compare without resynchronising the scan.

Reset
REQ-026 While rst_n=0: slot=0, frame=0, guard=0, PWM counter=0, and all seg_out and sel_out at their inactive level.
REQ-027 On rst_n deassertion mid-frame, scanning SHALL restart from slot 0 on the first ena_ms, whose step goes to DIGITS-1.
REQ-028 SHALL have no synchronous reset input.

Configuration
REQ-029 With CONFIG_SEGSCAN_DIM_EN defined: a free-running DIM_W-bit PWM counter increments every clk, wraps at all-ones, and pwm_on = (cnt <= dim); dim=all-ones means always on, dim=0 means on 1/2^DIM_W of the time.
REQ-030 Without CONFIG_SEGSCAN_DIM_EN: pwm_on is constant 1, dim is ignored, and no PWM counter is synthesised.

Structure
REQ-031 Shared package wbc_seg_pkg SHALL hold the clog2 function and the active-low/active-high polarity constants, for reuse by board top levels.
REQ-032 The PWM generator SHALL be the single sub-module wbc_segpwm (clk, rst_n, dim, on), instantiated only under CONFIG_SEGSCAN_DIM_EN.
REQ-033 The scan counter, guard and output registers SHALL live in wbc_segscan.

Verification
REQ-034 Reset release then DIGITS=6, ena_ms every 10 clk -> slot sequence 0,5,4,3,2,1,0,5; frame pulses one clk after each 0->5 step.
REQ-035 seg_data digit 3 = 0x3F, all dig_ena=1, dim all-ones, slot=3 -> seg_out=~0x3F and sel_out=6'b110111 one clk later; all inactive in the guard clk after ena_ms.
REQ-036 dig_ena=6'b111011 -> during slot 2 sel_out=6'b111111 and seg_out=8'hFF; slot timing unchanged.
REQ-037 blank=1 together with ena_ms -> slot advances, outputs inactive; blank=0 -> slot digit shown next clk.
REQ-038 DIM on, DIM_W=3, dim=1 -> lit on 2 of every 8 clk within a slot; dim=7 -> lit on every non-guard clk; DIM off -> dim ignored.
REQ-039 rst_n pulsed low mid-slot 4, asynchronously -> outputs inactive immediately; after release slot=0, then 5 on the next ena_ms.
